// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, parity selectors and the
// three-sample vote used by the oversampler.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and mid-bit 3-sample majority vote. The voted value is registered
// two edges past the bit centre, so it is stable well before bit_end.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               run,
    input  logic               rx,
    input  logic [PRESC_W-1:0] prescale,
    output logic               sample,
    output logic               bit_end
);

    logic [PRESC_W-1:0] edge_cnt_q;
    logic [PRESC_W-1:0] half;
    logic [2:0]         votes_q;

    assign half    = prescale >> 1;
    assign bit_end = run && (edge_cnt_q == prescale - PRESC_W'(1));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            edge_cnt_q <= '0;
            votes_q    <= '0;
            sample     <= 1'b1;
        end else if (run) begin
            edge_cnt_q <= bit_end ? '0 : edge_cnt_q + PRESC_W'(1);
            if (edge_cnt_q == half - PRESC_W'(1)) votes_q[0] <= rx;
            if (edge_cnt_q == half)               votes_q[1] <= rx;
            if (edge_cnt_q == half + PRESC_W'(1)) votes_q[2] <= rx;
            if (edge_cnt_q == half + PRESC_W'(2)) sample     <= majority3(votes_q);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receive core: start detection, LSB-first data shift, optional parity and stop check.
// Frame settings are captured on the start edge so a frame is decoded with one timing.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned width   = 8,
    parameter int unsigned PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    output logic [width-1:0]   P_Data,
    output logic               Data_valid,
    output logic               Par_err,
    output logic               Stp_err
);

    localparam int unsigned CntW = $clog2(width) + 1;

    rx_state_e          state_q;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc;
    logic               par_en_q;
    logic               par_typ_q;
    logic               par_bad_q;
    logic [CntW-1:0]    bit_cnt_q;
    logic [width-1:0]   shift_q;
    logic               run;
    logic               sample;
    logic               bit_end;
    logic               exp_par;

    // The start cycle itself is edge 0, so the counter runs while IDLE sees the line low.
    assign run     = (state_q != StIdle) || !RX_IN;
    assign presc   = (state_q == StIdle) ? Prescale : presc_q;
    assign exp_par = (^shift_q) ^ (par_typ_q == PAR_ODD);

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .CLK      (CLK),
        .Reset    (Reset),
        .run      (run),
        .rx       (RX_IN),
        .prescale (presc),
        .sample   (sample),
        .bit_end  (bit_end)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            P_Data     <= '0;
            Data_valid <= 1'b0;
            Par_err    <= 1'b0;
            Stp_err    <= 1'b0;
        end else begin
            Data_valid <= 1'b0;
            Par_err    <= 1'b0;
            Stp_err    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!RX_IN) begin
                        state_q   <= StStart;
                        presc_q   <= Prescale;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_bad_q <= 1'b0;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        if (sample) begin
                            state_q <= StIdle;
                        end else begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                        end
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shift_q <= {sample, shift_q[width-1:1]};
                        if (bit_cnt_q == CntW'(width - 1)) begin
                            state_q <= par_en_q ? StParity : StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CntW'(1);
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state_q <= StStop;
                        if (sample != exp_par) begin
                            Par_err   <= 1'b1;
                            par_bad_q <= 1'b1;
                        end
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        state_q <= StIdle;
                        if (!sample) begin
                            Stp_err <= 1'b1;
                        end else if (!par_bad_q) begin
                            Data_valid <= 1'b1;
                            P_Data     <= shift_q;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are described at bit level, the expected pulse cycles
// and words are scheduled from frame length arithmetic and checked on every falling edge.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_Data;
    logic       Data_valid;
    logic       Par_err;
    logic       Stp_err;

    uart_rx #(
        .width   (8),
        .PRESC_W (6)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_Data     (P_Data),
        .Data_valid (Data_valid),
        .Par_err    (Par_err),
        .Stp_err    (Stp_err)
    );

    always #5 CLK = ~CLK;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         dv_cnt = 0;
    int         pe_cnt = 0;
    int         se_cnt = 0;
    int         last_dv_cyc = -1;
    int         t_start;
    logic [7:0] model_word = 8'h00;
    logic [7:0] dv_words[$];
    bit         exp_dv[int];
    bit         exp_pe[int];
    bit         exp_se[int];
    logic [7:0] exp_word[int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Hold RX_IN for one cycle and compare all outputs against the schedule mid-cycle.
    task automatic drive_cycle(input logic v);
        bit e_dv;
        bit e_pe;
        bit e_se;
        RX_IN = v;
        @(negedge CLK);
        if (!Reset) model_word = 8'h00;
        e_dv = exp_dv.exists(cyc);
        e_pe = exp_pe.exists(cyc);
        e_se = exp_se.exists(cyc);
        if (e_dv) model_word = exp_word[cyc];
        check("data_valid", 32'(Data_valid), 32'(e_dv));
        check("par_err", 32'(Par_err), 32'(e_pe));
        check("stp_err", 32'(Stp_err), 32'(e_se));
        check("p_data", 32'(P_Data), 32'(model_word));
        if (Data_valid === 1'b1) begin
            dv_cnt++;
            last_dv_cyc = cyc;
            dv_words.push_back(P_Data);
        end
        if (Par_err === 1'b1) pe_cnt++;
        if (Stp_err === 1'b1) se_cnt++;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1);
    endtask

    function automatic logic good_par(input logic [7:0] d, input logic typ);
        return logic'($countones(d) % 2) ^ typ;
    endfunction

    // Sends one frame; glitch inverts the first cycle of frame bit index glitch (-1: none).
    task automatic send_frame(input int p, input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic pbit, input logic stp, input int glitch);
        int   n;
        int   t0;
        bit   par_ok;
        logic bits[11];
        n  = 10 + int'(pen);
        t0 = cyc;
        par_ok = !pen || (pbit == good_par(d, ptyp));
        if (pen && !par_ok) exp_pe[t0 + (n - 1) * p] = 1'b1;
        if (!stp) begin
            exp_se[t0 + n * p] = 1'b1;
        end else if (par_ok) begin
            exp_dv[t0 + n * p]   = 1'b1;
            exp_word[t0 + n * p] = d;
        end
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i + 1] = d[i];
        bits[9]     = pbit;
        bits[n - 1] = stp;
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < p; c++) begin
                drive_cycle((b == glitch && c == 0) ? ~bits[b] : bits[b]);
                if (b == 0 && c == 0) begin
                    // Settings must have been captured at the start edge.
                    Prescale = (p == 8) ? 6'd16 : 6'd8;
                    PAR_EN   = ~pen;
                    PAR_TYP  = ~ptyp;
                end
            end
        end
    endtask

    int dv0, pe0, se0;

    initial begin
        Reset = 1'b0;
        RX_IN = 1'b1;
        Prescale = 6'd8;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        @(posedge CLK);
        #1;
        idle(3);
        check("reset_p_data", 32'(P_Data), 32'h0);
        check("reset_flags", {29'd0, Data_valid, Par_err, Stp_err}, 32'h0);
        Reset = 1'b1;
        idle(4);

        // 1: P=8, no parity, 0xA5 with a low glitch at the first edge of data bit 2
        dv0 = dv_cnt;
        t_start = cyc;
        send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        idle(3);
        check("t1_dv_count", 32'(dv_cnt - dv0), 32'd1);
        check("t1_latency", 32'(last_dv_cyc - t_start), 32'd80);
        check("t1_word", 32'(P_Data), 32'hA5);

        // 2: P=16, even parity, good then bad parity bit
        dv0 = dv_cnt;
        pe0 = pe_cnt;
        send_frame(16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        idle(2);
        check("t2_word", 32'(P_Data), 32'h3C);
        send_frame(16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        idle(2);
        check("t2_dv_count", 32'(dv_cnt - dv0), 32'd1);
        check("t2_par_err_count", 32'(pe_cnt - pe0), 32'd1);
        check("t2_word_held", 32'(P_Data), 32'h3C);

        // 3: P=8, bad stop bit, then a clean frame
        dv0 = dv_cnt;
        se0 = se_cnt;
        send_frame(8, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check("t3_word_held", 32'(P_Data), 32'h3C);
        idle(3);
        send_frame(8, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(2);
        check("t3_stp_err_count", 32'(se_cnt - se0), 32'd1);
        check("t3_dv_count", 32'(dv_cnt - dv0), 32'd1);
        check("t3_word", 32'(P_Data), 32'h0F);

        // 4: P=16, false start (3 low cycles)
        dv0 = dv_cnt;
        pe0 = pe_cnt;
        se0 = se_cnt;
        Prescale = 6'd16;
        PAR_EN = 1'b0;
        idle(0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0);
        idle(40);
        check("t4_no_pulses", 32'((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)), 32'd0);
        check("t4_word_held", 32'(P_Data), 32'h0F);

        // 5: P=32, odd parity, back-to-back frames
        dv0 = dv_cnt;
        dv_words.delete();
        send_frame(32, 8'h01, 1'b1, 1'b1, good_par(8'h01, 1'b1), 1'b1, -1);
        send_frame(32, 8'hFF, 1'b1, 1'b1, good_par(8'hFF, 1'b1), 1'b1, -1);
        idle(3);
        check("t5_dv_count", 32'(dv_cnt - dv0), 32'd2);
        check("t5_first_word", 32'(dv_words.size() > 0 ? dv_words[0] : 8'hxx), 32'h01);
        check("t5_word", 32'(P_Data), 32'hFF);

        // 6: reset in the middle of data bit 4, then a clean frame
        Prescale = 6'd8;
        PAR_EN = 1'b0;
        drive_cycle(1'b0);
        Prescale = 6'd16;
        for (int i = 1; i < 8; i++) drive_cycle(1'b0);
        for (int b = 0; b < 4; b++) for (int c = 0; c < 8; c++) drive_cycle(b[0]);
        for (int c = 0; c < 4; c++) drive_cycle(1'b1);
        Reset = 1'b0;
        #1;
        check("t6_reset_p_data", 32'(P_Data), 32'h0);
        check("t6_reset_flags", {29'd0, Data_valid, Par_err, Stp_err}, 32'h0);
        idle(2);
        Reset = 1'b1;
        idle(3);
        dv0 = dv_cnt;
        send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(3);
        check("t6_dv_count", 32'(dv_cnt - dv0), 32'd1);
        check("t6_word", 32'(P_Data), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
